// File: rtl/prime_pkg.sv
// ============================================================================
// prime_pkg : shared FSM encodings and default sizing for the prime sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package prime_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_CNT_W    = 4;
   localparam int DEF_MAX_CAND = (1 << DEF_WIDTH) - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TEST = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/prime_trial_step.sv
// ============================================================================
// prime_trial_step : one trial-division step (square bound and divisibility)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module prime_trial_step
   import prime_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] cand,
   input  logic [WIDTH-1:0] div,
   output logic             is_prime_done,
   output logic             is_divisible
);

   logic [2*WIDTH-1:0] w_div_sq;
   logic [WIDTH-1:0]   w_rem;

   // Square kept at double width so the bound test never truncates.
   assign w_div_sq      = {{WIDTH{1'b0}}, div} * {{WIDTH{1'b0}}, div};
   assign is_prime_done = (w_div_sq > {{WIDTH{1'b0}}, cand});
   assign w_rem         = (div != '0) ? (cand % div) : cand;
   assign is_divisible  = (div != '0) && (w_rem == '0);

endmodule

`default_nettype wire

// File: rtl/prime_number_generator.sv
// ============================================================================
// prime_number_generator : streams the first N primes over a valid/ready port
// Revision               : 1.0
// ============================================================================
`default_nettype none

module prime_number_generator
   import prime_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] max_count,
   output logic [WIDTH-1:0] prime_out,
   output logic             prime_valid,
   input  logic             prime_ready,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             exhausted
);

   localparam logic [WIDTH-1:0] C_MAX_CAND = '1;
   localparam logic [WIDTH-1:0] C_FIRST    = WIDTH'(2);

   state_t           r_state;
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_div;
   logic [CNT_W-1:0] r_tgt;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_prime_out;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_exhausted;

   logic             w_prime_done;
   logic             w_divisible;
   logic [CNT_W-1:0] w_count_inc;
   logic             w_at_top;

   prime_trial_step #(.WIDTH(WIDTH)) u_step (
      .cand          (r_cand),
      .div           (r_div),
      .is_prime_done (w_prime_done),
      .is_divisible  (w_divisible)
   );

   assign w_count_inc = r_count + CNT_W'(1);
   assign w_at_top    = (r_cand == C_MAX_CAND);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cand      <= '0;
         r_div       <= '0;
         r_tgt       <= '0;
         r_count     <= '0;
         r_prime_out <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_exhausted <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_tgt       <= max_count;
                  r_count     <= '0;
                  r_exhausted <= 1'b0;
                  r_cand      <= C_FIRST;
                  r_div       <= C_FIRST;
                  if (max_count == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_TEST;
                     r_done  <= 1'b0;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_TEST: begin
               if (w_prime_done) begin
                  r_prime_out <= r_cand;
                  r_valid     <= 1'b1;
                  r_state     <= ST_EMIT;
               end else if (w_divisible) begin
                  if (w_at_top) begin
                     r_exhausted <= 1'b1;
                     r_done      <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= ST_DONE;
                  end else begin
                     r_cand <= r_cand + WIDTH'(1);
                     r_div  <= C_FIRST;
                  end
               end else begin
                  r_div <= r_div + WIDTH'(1);
               end
            end
            ST_EMIT: begin
               if (r_valid && prime_ready) begin
                  r_valid <= 1'b0;
                  r_count <= w_count_inc;
                  if (w_count_inc == r_tgt) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_DONE;
                  end else if (w_at_top) begin
                     r_exhausted <= 1'b1;
                     r_done      <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= ST_DONE;
                  end else begin
                     r_cand  <= r_cand + WIDTH'(1);
                     r_div   <= C_FIRST;
                     r_state <= ST_TEST;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign prime_out   = r_prime_out;
   assign prime_valid = r_valid;
   assign count       = r_count;
   assign busy        = r_busy;
   assign done        = r_done;
   assign exhausted   = r_exhausted;

endmodule

`default_nettype wire

// File: tb/tb_prime_number_generator.sv
// ============================================================================
// tb_prime_number_generator : scoreboard bench for two sizings of the sequencer
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module tb_prime_number_generator;

   logic       clk;
   logic       rst;
   logic       start_a, start_b;
   logic [3:0] max_a, max_b;
   logic [7:0] prime_a;
   logic [3:0] prime_b;
   logic       valid_a, valid_b;
   logic       ready_a, ready_b;
   logic [3:0] count_a, count_b;
   logic       busy_a, busy_b, done_a, done_b, exh_a, exh_b;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] q_a[$];
   logic [3:0] q_b[$];

   prime_number_generator #(.WIDTH(8), .CNT_W(4)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .max_count(max_a),
      .prime_out(prime_a), .prime_valid(valid_a), .prime_ready(ready_a),
      .count(count_a), .busy(busy_a), .done(done_a), .exhausted(exh_a)
   );

   prime_number_generator #(.WIDTH(4), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .max_count(max_b),
      .prime_out(prime_b), .prime_valid(valid_b), .prime_ready(ready_b),
      .count(count_b), .busy(busy_b), .done(done_b), .exhausted(exh_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Inputs change #1 after posedge, so at negedge they already show what the next edge samples.
   always @(negedge clk) begin
      if (rst && valid_a && ready_a) begin
         if (q_a.size() == 0) check("a_unexpected_prime", int'(prime_a), -1);
         else check("a_prime", int'(prime_a), int'(q_a.pop_front()));
      end
      if (rst && valid_b && ready_b) begin
         if (q_b.size() == 0) check("b_unexpected_prime", int'(prime_b), -1);
         else check("b_prime", int'(prime_b), int'(q_b.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run_a(input logic [3:0] n);
      max_a   = n;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string name);
      int n = 0;
      while (!done_a && n < 2000) begin
         tick();
         n++;
      end
      check(name, int'(done_a), 1);
   endtask

   task automatic check_all_zero_a(input string tag);
      check({tag, "_prime_out"}, int'(prime_a), 0);
      check({tag, "_valid"},     int'(valid_a), 0);
      check({tag, "_count"},     int'(count_a), 0);
      check({tag, "_busy"},      int'(busy_a),  0);
      check({tag, "_done"},      int'(done_a),  0);
      check({tag, "_exhausted"}, int'(exh_a),   0);
   endtask

   initial begin
      int n;
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      max_a = '0; max_b = '0; ready_a = 1'b1; ready_b = 1'b1;
      tick(); tick();
      check_all_zero_a("reset");
      check("reset_b_done", int'(done_b), 0);
      rst = 1'b1;
      tick();

      // Basic run of five primes with no backpressure
      q_a.push_back(8'd2); q_a.push_back(8'd3); q_a.push_back(8'd5);
      q_a.push_back(8'd7); q_a.push_back(8'd11);
      start_run_a(4'd5);
      check("basic_busy", int'(busy_a), 1);
      wait_done_a("basic_done");
      check("basic_count", int'(count_a), 5);
      check("basic_exhausted", int'(exh_a), 0);
      check("basic_busy_low", int'(busy_a), 0);
      check("basic_last_prime", int'(prime_a), 11);
      check("basic_queue_empty", q_a.size(), 0);

      // Backpressure on prime 3
      q_a.push_back(8'd2); q_a.push_back(8'd3); q_a.push_back(8'd5);
      start_run_a(4'd3);
      n = 0;
      while (count_a != 4'd1 && n < 200) begin tick(); n++; end
      check("bp_first_transfer", int'(count_a), 1);
      ready_a = 1'b0;
      n = 0;
      while (!valid_a && n < 200) begin tick(); n++; end
      check("bp_valid_up", int'(valid_a), 1);
      for (int i = 0; i < 10; i++) tick();
      check("bp_prime_held", int'(prime_a), 3);
      check("bp_valid_held", int'(valid_a), 1);
      check("bp_count_held", int'(count_a), 1);
      ready_a = 1'b1;
      wait_done_a("bp_done");
      check("bp_count", int'(count_a), 3);

      // Zero request: no prime, done within two edges
      start_run_a(4'd0);
      tick();
      check("zero_done", int'(done_a), 1);
      check("zero_count", int'(count_a), 0);
      check("zero_valid", int'(valid_a), 0);
      check("zero_busy", int'(busy_a), 0);

      // Exhaustion on the 4-bit instance
      q_b.push_back(4'd2); q_b.push_back(4'd3); q_b.push_back(4'd5);
      q_b.push_back(4'd7); q_b.push_back(4'd11); q_b.push_back(4'd13);
      max_b = 4'd10; start_b = 1'b1; tick(); start_b = 1'b0;
      n = 0;
      while (!done_b && n < 2000) begin tick(); n++; end
      check("exh_done", int'(done_b), 1);
      check("exh_flag", int'(exh_b), 1);
      check("exh_count", int'(count_b), 6);
      check("exh_queue_empty", q_b.size(), 0);

      // Reset while a prime is pending
      ready_a = 1'b0;
      start_run_a(4'd5);
      n = 0;
      while (!valid_a && n < 200) begin tick(); n++; end
      check("mid_valid_up", int'(valid_a), 1);
      rst = 1'b0;
      tick();
      check_all_zero_a("midreset");
      rst = 1'b1; ready_a = 1'b1;
      tick();
      q_a.push_back(8'd2); q_a.push_back(8'd3);
      start_run_a(4'd2);
      wait_done_a("restart_done");
      check("restart_count", int'(count_a), 2);

      // start pulsed during TEST is ignored
      q_a.push_back(8'd2);
      max_a = 4'd1; start_a = 1'b1; tick();
      max_a = 4'd9; tick();
      start_a = 1'b0;
      wait_done_a("ignore_done");
      check("ignore_count", int'(count_a), 1);
      q_a.push_back(8'd2); q_a.push_back(8'd3); q_a.push_back(8'd5);
      start_run_a(4'd3);
      wait_done_a("rerun_done");
      check("rerun_count", int'(count_a), 3);
      tick(); tick();
      check("final_queue_a_empty", q_a.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
